// File: rtl/rect_border_plotter.sv
// Paced rectangle plotter for the vga_adapter write port: outline by default,
// row-major fill when RECT_FILL_EN is defined and fill=1 at start.
module rect_border_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
`ifdef RECT_FILL_EN
  input  logic                fill,
`endif
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out
);

  localparam int PACE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(STEP_DIV - 1);
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_TOP, S_BOTTOM, S_LEFT, S_RIGHT, S_FILL, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [X_W-1:0]      xmin_q, xmin_d, xmax_q, xmax_d, cx_q, cx_d;
  logic [Y_W-1:0]      ymin_q, ymin_d, ymax_q, ymax_d, cy_q, cy_d;
  logic [COLOUR_W-1:0] col_q, col_d;
  logic [PACE_W-1:0]   pace_q, pace_d;
  logic                busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W-1:0]      x_out_q, x_out_d;
  logic [Y_W-1:0]      y_out_q, y_out_d;
  logic [COLOUR_W-1:0] colour_out_q, colour_out_d;

  logic [X_W-1:0] cx0, cx1, xmin_n, xmax_n;
  logic [Y_W-1:0] cy0, cy1, ymin_n, ymax_n;
  logic [Y_W-1:0] side_last;
  logic           has_sides;

  // Clip each corner first, then order; every counter endpoint stays in range.
  assign cx0    = (x0 > X_LIM) ? X_LIM : x0;
  assign cx1    = (x1 > X_LIM) ? X_LIM : x1;
  assign cy0    = (y0 > Y_LIM) ? Y_LIM : y0;
  assign cy1    = (y1 > Y_LIM) ? Y_LIM : y1;
  assign xmin_n = (cx0 < cx1) ? cx0 : cx1;
  assign xmax_n = (cx0 < cx1) ? cx1 : cx0;
  assign ymin_n = (cy0 < cy1) ? cy0 : cy1;
  assign ymax_n = (cy0 < cy1) ? cy1 : cy0;

  assign side_last = ymax_q - 1'b1;
  assign has_sides = (ymax_q - ymin_q) > Y_W'(1);

  always_comb begin
    state_d      = state_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    col_d        = col_q;
    pace_d       = pace_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    plot_d       = 1'b0;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          xmin_d = xmin_n;
          xmax_d = xmax_n;
          ymin_d = ymin_n;
          ymax_d = ymax_n;
          cx_d   = xmin_n;
          cy_d   = ymin_n;
          col_d  = colour;
          pace_d = '0;
`ifdef RECT_FILL_EN
          state_d = fill ? S_FILL : S_TOP;
`else
          state_d = S_TOP;
`endif
        end
      end

      S_TOP, S_BOTTOM, S_LEFT, S_RIGHT, S_FILL: begin
        busy_d = 1'b1;
        if (pace_q != '0) begin
          pace_d = pace_q - 1'b1;
        end else begin
          plot_d       = 1'b1;
          x_out_d      = cx_q;
          y_out_d      = cy_q;
          colour_out_d = col_q;
          pace_d       = PACE_RELOAD;
          // Each edge hands over to the next only if it adds unplotted pixels.
          case (state_q)
            S_TOP: begin
              if (cx_q != xmax_q) cx_d = cx_q + 1'b1;
              else if (ymin_q == ymax_q) state_d = S_DONE;
              else begin
                state_d = S_BOTTOM;
                cx_d    = xmin_q;
                cy_d    = ymax_q;
              end
            end
            S_BOTTOM: begin
              if (cx_q != xmax_q) cx_d = cx_q + 1'b1;
              else if (!has_sides) state_d = S_DONE;
              else begin
                state_d = S_LEFT;
                cx_d    = xmin_q;
                cy_d    = ymin_q + 1'b1;
              end
            end
            S_LEFT: begin
              if (cy_q != side_last) cy_d = cy_q + 1'b1;
              else if (xmin_q == xmax_q) state_d = S_DONE;
              else begin
                state_d = S_RIGHT;
                cx_d    = xmax_q;
                cy_d    = ymin_q + 1'b1;
              end
            end
            S_RIGHT: begin
              if (cy_q != side_last) cy_d = cy_q + 1'b1;
              else state_d = S_DONE;
            end
            default: begin
              if (cx_q != xmax_q) cx_d = cx_q + 1'b1;
              else if (cy_q == ymax_q) state_d = S_DONE;
              else begin
                cx_d = xmin_q;
                cy_d = cy_q + 1'b1;
              end
            end
          endcase
        end
      end

      S_DONE: begin
        if (pace_q != '0) begin
          pace_d = pace_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      col_q        <= '0;
      pace_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
    end else begin
      state_q      <= state_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      col_q        <= col_d;
      pace_q       <= pace_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      plot_q       <= plot_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;

endmodule
